morse_key_decoder: RTL and testbench

- Receive-side counterpart of the Morse keyer path. Takes a raw push-button key and measures debounced mark/space durations against a dit unit.
- Classifies each mark as dot or dash and emits one 5-bit letter code per character, in seg7alp-compatible A=0..Z=25 code space.
- Sits beside TX/RX under the Morse top level. Its outputs feed the HEX display mux and status LEDs.

---
 rtl/morse_key_decoder.sv | 179 +++++++++++++++++
 tb/tb_morse_key_decoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_decoder.sv
// Morse receive decoder: synchronises and debounces a raw key, times marks/spaces against a dit unit, emits A..Z codes.
// Latency: char_valid rises 3 units after the last debounced release; no backpressure, pulses are one cycle and must be taken.
module morse_key_decoder #(
    parameter int UNIT_CYCLES = 12500000,
    parameter int DEB_CYCLES  = 500000,
    parameter int CNT_W       = 28
) (
    input  logic       iCLK,
    input  logic       rst,
    input  logic       key_n,
    input  logic       en,
    output logic       char_valid,
    output logic [4:0] char_code,
    output logic [4:0] sym_pattern,
    output logic [2:0] sym_len,
    output logic       word_gap,
    output logic       err,
    output logic       key_led,
    output logic       busy
);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] EMIT_AT  = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WORD_AT  = CNT_W'(7 * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

    state_t           state, state_nxt;
    logic             sync1, sync2, key_db, key_db_d;
    logic [DEB_W-1:0] deb_cnt;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       pat;
    logic [2:0]       len;
    logic             ovf;
    logic             rise, fall, emit, push, wg_hit, sym_dash;
    logic [4:0]       code;

    function automatic logic [4:0] lookup(input logic [2:0] l, input logic [4:0] p);
        case ({l, p})
            {3'd2, 5'b00010}: return 5'd0;
            {3'd4, 5'b00001}: return 5'd1;
            {3'd4, 5'b00101}: return 5'd2;
            {3'd3, 5'b00001}: return 5'd3;
            {3'd1, 5'b00000}: return 5'd4;
            {3'd4, 5'b00100}: return 5'd5;
            {3'd3, 5'b00011}: return 5'd6;
            {3'd4, 5'b00000}: return 5'd7;
            {3'd2, 5'b00000}: return 5'd8;
            {3'd4, 5'b01110}: return 5'd9;
            {3'd3, 5'b00101}: return 5'd10;
            {3'd4, 5'b00010}: return 5'd11;
            {3'd2, 5'b00011}: return 5'd12;
            {3'd2, 5'b00001}: return 5'd13;
            {3'd3, 5'b00111}: return 5'd14;
            {3'd4, 5'b00110}: return 5'd15;
            {3'd4, 5'b01011}: return 5'd16;
            {3'd3, 5'b00010}: return 5'd17;
            {3'd3, 5'b00000}: return 5'd18;
            {3'd1, 5'b00001}: return 5'd19;
            {3'd3, 5'b00100}: return 5'd20;
            {3'd4, 5'b01000}: return 5'd21;
            {3'd3, 5'b00110}: return 5'd22;
            {3'd4, 5'b01001}: return 5'd23;
            {3'd4, 5'b01101}: return 5'd24;
            {3'd4, 5'b00011}: return 5'd25;
            default:          return 5'd31;
        endcase
    endfunction

    always_ff @(posedge iCLK) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            key_db   <= 1'b0;
            key_db_d <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            sync1    <= ~key_n;
            sync2    <= sync1;
            key_db_d <= key_db;
            if (sync2 == key_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                key_db  <= ~key_db;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    assign rise = key_db & ~key_db_d;
    assign fall = ~key_db & key_db_d;

    // cnt holds the number of cycles elapsed since the last debounced edge
    always_ff @(posedge iCLK) begin
        if (rst)              cnt <= '0;
        else if (rise | fall) cnt <= CNT_W'(1);
        else if (cnt != '1)   cnt <= cnt + CNT_W'(1);
    end

    assign sym_dash = (cnt >= DASH_MIN);
    assign code     = ovf ? 5'd31 : lookup(len, pat);

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        push      = 1'b0;
        wg_hit    = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (rise) state_nxt = MARK;
                MARK:  if (fall) begin
                           push      = 1'b1;
                           state_nxt = SPACE;
                       end
                SPACE: if (cnt == EMIT_AT) begin
                           emit      = 1'b1;
                           state_nxt = rise ? MARK : GAP;
                       end else if (rise) begin
                           state_nxt = MARK;
                       end
                GAP:   if (rise) begin
                           state_nxt = MARK;
                       end else if (cnt == WORD_AT) begin
                           wg_hit    = 1'b1;
                           state_nxt = IDLE;
                       end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (rst) begin
            state       <= IDLE;
            pat         <= '0;
            len         <= '0;
            ovf         <= 1'b0;
            char_valid  <= 1'b0;
            char_code   <= 5'd31;
            sym_pattern <= '0;
            sym_len     <= '0;
            word_gap    <= 1'b0;
            err         <= 1'b0;
        end else begin
            state      <= state_nxt;
            char_valid <= emit;
            word_gap   <= wg_hit;
            err        <= emit && (code == 5'd31);
            if (!en) begin
                pat <= '0;
                len <= '0;
                ovf <= 1'b0;
            end else if (emit) begin
                sym_pattern <= pat;
                sym_len     <= len;
                char_code   <= code;
                pat         <= '0;
                len         <= '0;
                ovf         <= 1'b0;
            end else if (push) begin
                // a sixth symbol cannot be stored; the letter is flagged instead
                if (len < 3'd5) begin
                    pat <= pat | (5'(sym_dash) << len);
                    len <= len + 3'd1;
                end else begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    assign key_led = key_db;
    assign busy    = (state == MARK) || (state == SPACE);
endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder: timeline model of key timing and letter lookup, plus directed literal checks.
module tb_morse_key_decoder;
    localparam int U   = 4;
    localparam int DEB = 2;

    logic       iCLK = 1'b0;
    logic       rst, key_n, en;
    logic       char_valid, word_gap, err, key_led, busy;
    logic [4:0] char_code, sym_pattern;
    logic [2:0] sym_len;

    morse_key_decoder #(.UNIT_CYCLES(U), .DEB_CYCLES(DEB), .CNT_W(28)) dut (
        .iCLK(iCLK), .rst(rst), .key_n(key_n), .en(en),
        .char_valid(char_valid), .char_code(char_code), .sym_pattern(sym_pattern),
        .sym_len(sym_len), .word_gap(word_gap), .err(err), .key_led(key_led), .busy(busy)
    );

    always #5 iCLK = ~iCLK;

    int n_chk = 0, n_fail = 0, cyc = 0, rel_cyc = 0, led_cnt = 0;
    bit chk_on = 0;
    int ev_code[$], ev_pat[$], ev_len[$], ev_err[$], ev_cyc[$], wg_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: letters as dot/dash strings, timing as absolute cycle stamps of debounced edges
    string morse[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                         "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                         "..-", "...-", ".--", "-..-", "-.--", "--.."};

    function automatic int lookup(input string s);
        for (int i = 0; i < 26; i++) if (s == morse[i]) return i;
        return 31;
    endfunction

    function automatic logic [4:0] pattern_of(input string s);
        logic [4:0] p = '0;
        byte c;
        for (int i = 0; i < s.len() && i < 5; i++) begin
            c = s[i];
            if (c == "-") p[i] = 1'b1;
        end
        return p;
    endfunction

    bit m_s1, m_s2, m_kd, m_kd_prev, m_mark, m_open, m_gap;
    int m_run, m_rise_t, m_fall_t;
    string m_sym;
    bit e_cv, e_wg, e_err;
    logic [4:0] e_code = 5'd31, e_pat = '0;
    logic [2:0] e_len = '0;

    task automatic model_step();
        bit rise, fall, kd_old;
        int code, n;
        rise = m_kd && !m_kd_prev;
        fall = !m_kd && m_kd_prev;
        e_cv = 0; e_wg = 0; e_err = 0;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_kd = 0; m_kd_prev = 0; m_run = 0;
            m_sym = ""; m_mark = 0; m_open = 0; m_gap = 0;
            e_code = 5'd31; e_pat = '0; e_len = '0;
        end else begin
            if (!en) begin
                m_sym = ""; m_mark = 0; m_open = 0; m_gap = 0;
            end else if (m_mark) begin
                if (fall) begin
                    if (cyc - m_rise_t >= 2 * U) m_sym = {m_sym, "-"};
                    else                         m_sym = {m_sym, "."};
                    m_mark = 0; m_open = 1; m_fall_t = cyc;
                end
            end else begin
                if (m_open && (cyc + 1 - m_fall_t == 3 * U)) begin
                    code = lookup(m_sym);
                    n = m_sym.len();
                    e_cv = 1; e_code = 5'(code); e_pat = pattern_of(m_sym);
                    e_len = 3'((n > 5) ? 5 : n); e_err = (code == 31);
                    m_sym = ""; m_open = 0; m_gap = !rise;
                end
                if (rise) begin
                    m_mark = 1; m_rise_t = cyc; m_gap = 0;
                end else if (m_gap && (cyc + 1 - m_fall_t == 7 * U)) begin
                    e_wg = 1; m_gap = 0;
                end
            end
            kd_old = m_kd;
            if (m_s2 != m_kd) begin
                m_run++;
                if (m_run == DEB) begin m_kd = !m_kd; m_run = 0; end
            end else m_run = 0;
            m_s2 = m_s1; m_s1 = !key_n; m_kd_prev = kd_old;
        end
    endtask

    initial forever begin
        @(posedge iCLK);
        model_step();
        cyc++;
    end

    initial forever begin
        @(negedge iCLK);
        if (chk_on) begin
            chk("char_valid", char_valid, e_cv);
            chk("char_code", char_code, e_code);
            chk("sym_pattern", sym_pattern, e_pat);
            chk("sym_len", sym_len, e_len);
            chk("word_gap", word_gap, e_wg);
            chk("err", err, e_err);
            chk("key_led", key_led, m_kd);
            chk("busy", busy, m_mark || m_open);
            if (char_valid === 1'b1) begin
                ev_code.push_back(char_code); ev_pat.push_back(sym_pattern);
                ev_len.push_back(sym_len); ev_err.push_back(err); ev_cyc.push_back(cyc);
            end
            if (word_gap === 1'b1) wg_cyc.push_back(cyc);
            if (key_led === 1'b1) led_cnt++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge iCLK); #1; end
    endtask

    task automatic key(input int hold, input int gap);
        key_n = 1'b0;
        cycles(hold);
        key_n = 1'b1;
        rel_cyc = cyc;
        cycles(gap);
    endtask

    task automatic clear_ev();
        ev_code.delete(); ev_pat.delete(); ev_len.delete(); ev_err.delete(); ev_cyc.delete();
        wg_cyc.delete(); led_cnt = 0;
    endtask

    initial begin
        rst = 1'b1; key_n = 1'b1; en = 1'b1;
        cycles(2);
        chk_on = 1;
        cycles(1);
        chk("reset char_code", char_code, 31);
        chk("reset char_valid", char_valid, 0);
        chk("reset sym_len", sym_len, 0);
        chk("reset busy/key_led", {busy, key_led}, 0);
        rst = 1'b0;
        cycles(2);

        // E: release edge is 2 sync + 2 debounce cycles after key_n, pulse 12 later
        clear_ev();
        key(3, 40);
        chk("E count", ev_code.size(), 1);
        chk("E code", ev_code[0], 4);
        chk("E pattern", ev_pat[0], 0);
        chk("E len", ev_len[0], 1);
        chk("E err", ev_err[0], 0);
        chk("E timing", ev_cyc[0] - rel_cyc, 16);

        clear_ev();
        key(4, 4);
        key(12, 40);
        chk("A code", ev_code[0], 0);
        chk("A pattern", ev_pat[0], 2);
        chk("A len", ev_len[0], 2);
        chk("A word_gap count", wg_cyc.size(), 1);
        chk("A word_gap timing", wg_cyc[0] - rel_cyc, 32);

        clear_ev();
        key(3, 4); key(3, 4); key(3, 12);
        key(12, 4); key(12, 4); key(12, 12);
        key(3, 4); key(3, 4); key(3, 40);
        chk("SOS count", ev_code.size(), 3);
        chk("SOS code0", ev_code[0], 18);
        chk("SOS code1", ev_code[1], 14);
        chk("SOS code2", ev_code[2], 18);
        chk("SOS pat0", ev_pat[0], 0);
        chk("SOS pat1", ev_pat[1], 7);
        chk("SOS pat2", ev_pat[2], 0);
        chk("SOS lens", {ev_len[0], ev_len[1], ev_len[2]}, {32'd3, 32'd3, 32'd3});
        chk("SOS word_gap count", wg_cyc.size(), 1);

        clear_ev();
        repeat (5) key(3, 4);
        key(3, 14);
        key(8, 40);
        chk("overflow count", ev_code.size(), 2);
        chk("overflow code", ev_code[0], 31);
        chk("overflow err", ev_err[0], 1);
        chk("overflow len", ev_len[0], 5);
        chk("overflow pattern", ev_pat[0], 0);
        chk("T code", ev_code[1], 19);
        chk("T err", ev_err[1], 0);
        chk("T pattern", ev_pat[1], 1);

        // one-cycle bounce during the space must not start a mark
        clear_ev();
        key(3, 5);
        key_n = 1'b0;
        cycles(1);
        key_n = 1'b1;
        cycles(40);
        chk("glitch count", ev_code.size(), 1);
        chk("glitch code", ev_code[0], 4);
        chk("glitch timing", ev_cyc[0] - (rel_cyc), 16);
        chk("glitch key_led cycles", led_cnt, 3);

        clear_ev();
        key_n = 1'b0;
        cycles(8);
        rst = 1'b1; key_n = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(40);
        chk("rst count", ev_code.size(), 0);
        chk("rst char_code", char_code, 31);
        chk("rst sym_len", sym_len, 0);
        chk("rst key_led", key_led, 0);

        clear_ev();
        key(8, 40);
        chk("pre-en T code", ev_code[0], 19);
        clear_ev();
        key(3, 5);
        en = 1'b0;
        cycles(2);
        en = 1'b1;
        cycles(40);
        chk("en count", ev_code.size(), 0);
        chk("en char_code hold", char_code, 19);
        chk("en sym_pattern hold", sym_pattern, 1);
        chk("en sym_len hold", sym_len, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
